// File: rtl/beta_lsu_dmem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : beta_lsu_dmem_ctrl
// Purpose  : Pipelined load/store unit with in-order load tracking.
// Revision : 1.0 - initial release
// ============================================================================
module beta_lsu_dmem_ctrl #(
  parameter int XLEN            = 32,
  parameter int ADDR_W          = 32,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic                req_op_i,
  input  logic [1:0]          req_size_i,
  input  logic                req_unsigned_i,
  input  logic [ADDR_W-1:0]   req_addr_i,
  input  logic [XLEN-1:0]     req_wdata_i,
  input  logic [4:0]          req_rd_i,
  output logic                dmem_req_valid_o,
  input  logic                dmem_req_ready_i,
  output logic                dmem_req_we_o,
  output logic [ADDR_W-1:0]   dmem_req_addr_o,
  output logic [XLEN/8-1:0]   dmem_req_be_o,
  output logic [XLEN-1:0]     dmem_req_wdata_o,
  input  logic                dmem_rsp_valid_i,
  input  logic [XLEN-1:0]     dmem_rsp_rdata_i,
  output logic                ld_valid_o,
  output logic [XLEN-1:0]     ld_data_o,
  output logic [4:0]          ld_rd_o,
  output logic                misaligned_o,
  output logic                busy_o
);

  localparam int c_BE_W  = XLEN / 8;
  localparam int c_OFS_W = $clog2(c_BE_W);
  localparam int c_PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int c_CNT_W = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic [0:0] {
    c_ST_IDLE = 1'b0,
    c_ST_WRDY = 1'b1
  } state_t;

  typedef struct packed {
    logic [1:0]         size;
    logic               uns;
    logic [c_OFS_W-1:0] ofs;
    logic [4:0]         rd;
  } trk_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [c_CNT_W-1:0] r_pending;
  logic [c_PTR_W-1:0] r_wptr;
  logic [c_PTR_W-1:0] r_rptr;
  trk_t               r_fifo [MAX_OUTSTANDING];

  logic               w_misal;
  logic               w_accept;
  logic               w_issue;
  logic               w_ld_push;
  logic               w_rsp_pop;
  logic [c_OFS_W-1:0] w_ofs;
  logic [c_BE_W-1:0]  w_be;
  logic [XLEN-1:0]    w_wdata;
  trk_t               w_trk_new;
  trk_t               w_head;
  logic [XLEN-1:0]    w_shift;
  logic [XLEN-1:0]    w_ext;

  assign w_ofs       = req_addr_i[c_OFS_W-1:0];
  assign req_ready_o = ((r_state == c_ST_IDLE) || dmem_req_ready_i) &&
                       (r_pending < c_CNT_W'(MAX_OUTSTANDING));
  assign w_accept    = req_valid_i & req_ready_o;
  assign w_issue     = w_accept & ~w_misal;
  assign w_ld_push   = w_issue & ~req_op_i;
  assign w_rsp_pop   = dmem_rsp_valid_i & (r_pending != '0);

  assign dmem_req_valid_o = (r_state == c_ST_WRDY);
  assign busy_o           = (r_state == c_ST_WRDY) || (r_pending != '0);

  always_comb begin
    w_misal = 1'b0;
    case (req_size_i)
      2'b00:   w_misal = |req_addr_i[1:0];
      2'b01:   w_misal = req_addr_i[0];
      2'b10:   w_misal = 1'b0;
      default: w_misal = (XLEN == 32) || (|req_addr_i[2:0]);
    endcase
  end

  always_comb begin
    w_be    = '1;
    w_wdata = req_wdata_i;
    case (req_size_i)
      2'b10: begin
        w_be    = c_BE_W'(1) << w_ofs;
        w_wdata = {c_BE_W{req_wdata_i[7:0]}};
      end
      2'b01: begin
        w_be    = c_BE_W'(3) << w_ofs;
        w_wdata = {(XLEN/16){req_wdata_i[15:0]}};
      end
      2'b00: begin
        w_be    = c_BE_W'(4'hF) << w_ofs;
        w_wdata = {(XLEN/32){req_wdata_i[31:0]}};
      end
      default: begin
        w_be    = '1;
        w_wdata = req_wdata_i;
      end
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_IDLE: if (w_issue) w_state_nxt = c_ST_WRDY;
      c_ST_WRDY: if (dmem_req_ready_i && !w_issue) w_state_nxt = c_ST_IDLE;
      default:   w_state_nxt = c_ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) r_state <= c_ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  // A new issue can only happen while the slot is free or being drained,
  // so loading on w_issue never overwrites a request memory has not taken.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      dmem_req_we_o    <= 1'b0;
      dmem_req_addr_o  <= '0;
      dmem_req_be_o    <= '0;
      dmem_req_wdata_o <= '0;
    end else if (w_issue) begin
      dmem_req_we_o    <= req_op_i;
      dmem_req_addr_o  <= {req_addr_i[ADDR_W-1:c_OFS_W], {c_OFS_W{1'b0}}};
      dmem_req_be_o    <= w_be;
      dmem_req_wdata_o <= w_wdata;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_pending <= '0;
      r_wptr    <= '0;
      r_rptr    <= '0;
    end else begin
      case ({w_ld_push, w_rsp_pop})
        2'b10:   r_pending <= r_pending + c_CNT_W'(1);
        2'b01:   r_pending <= r_pending - c_CNT_W'(1);
        default: r_pending <= r_pending;
      endcase
      if (w_ld_push)
        r_wptr <= (r_wptr == c_PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : r_wptr + c_PTR_W'(1);
      if (w_rsp_pop)
        r_rptr <= (r_rptr == c_PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : r_rptr + c_PTR_W'(1);
    end
  end

  assign w_trk_new = '{size: req_size_i, uns: req_unsigned_i, ofs: w_ofs, rd: req_rd_i};

  always_ff @(posedge clk_i) begin
    if (w_ld_push) r_fifo[r_wptr] <= w_trk_new;
  end

  assign w_head  = r_fifo[r_rptr];
  assign w_shift = dmem_rsp_rdata_i >> {w_head.ofs, 3'b000};

  // Width casts of signed operands sign-extend, unsigned ones zero-extend.
  always_comb begin
    w_ext = w_shift;
    case (w_head.size)
      2'b10:   w_ext = w_head.uns ? XLEN'(w_shift[7:0])  : XLEN'($signed(w_shift[7:0]));
      2'b01:   w_ext = w_head.uns ? XLEN'(w_shift[15:0]) : XLEN'($signed(w_shift[15:0]));
      2'b00:   w_ext = w_head.uns ? XLEN'(w_shift[31:0]) : XLEN'($signed(w_shift[31:0]));
      default: w_ext = w_shift;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ld_valid_o   <= 1'b0;
      ld_data_o    <= '0;
      ld_rd_o      <= '0;
      misaligned_o <= 1'b0;
    end else begin
      ld_valid_o   <= w_rsp_pop;
      misaligned_o <= w_accept & w_misal;
      if (w_rsp_pop) begin
        ld_data_o <= w_ext;
        ld_rd_o   <= w_head.rd;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_beta_lsu_dmem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_beta_lsu_dmem_ctrl
// Purpose  : Scoreboard bench for beta_lsu_dmem_ctrl (32-bit and 64-bit).
// Revision : 1.0 - initial release
// ============================================================================
module tb_beta_lsu_dmem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_op, req_uns, mem_ready, rsp_valid;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata, rsp_rdata;
  logic [4:0]  req_rd;
  logic        req_ready, dv, dwe, ld_valid, mis, busy;
  logic [31:0] daddr, dwdata, ld_data;
  logic [3:0]  dbe;
  logic [4:0]  ld_rd;

  logic        v64, op64, uns64, rspv64;
  logic [1:0]  size64;
  logic [31:0] addr64;
  logic [63:0] wdata64, rdata64;
  logic [4:0]  rd64;
  logic        rdy64, dv64, dwe64, ldv64, mis64, busy64;
  logic [31:0] daddr64;
  logic [7:0]  dbe64;
  logic [63:0] dwdata64, ldd64;
  logic [4:0]  ldrd64;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
  } exp_t;

  exp_t sb[$];
  exp_t e_mon;
  int   n_cmp  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  beta_lsu_dmem_ctrl #(.XLEN(32), .ADDR_W(32), .MAX_OUTSTANDING(2)) u_dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_op_i(req_op),
    .req_size_i(req_size), .req_unsigned_i(req_uns), .req_addr_i(req_addr),
    .req_wdata_i(req_wdata), .req_rd_i(req_rd),
    .dmem_req_valid_o(dv), .dmem_req_ready_i(mem_ready), .dmem_req_we_o(dwe),
    .dmem_req_addr_o(daddr), .dmem_req_be_o(dbe), .dmem_req_wdata_o(dwdata),
    .dmem_rsp_valid_i(rsp_valid), .dmem_rsp_rdata_i(rsp_rdata),
    .ld_valid_o(ld_valid), .ld_data_o(ld_data), .ld_rd_o(ld_rd),
    .misaligned_o(mis), .busy_o(busy)
  );

  beta_lsu_dmem_ctrl #(.XLEN(64), .ADDR_W(32), .MAX_OUTSTANDING(2)) u_dut64 (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(v64), .req_ready_o(rdy64), .req_op_i(op64),
    .req_size_i(size64), .req_unsigned_i(uns64), .req_addr_i(addr64),
    .req_wdata_i(wdata64), .req_rd_i(rd64),
    .dmem_req_valid_o(dv64), .dmem_req_ready_i(1'b1), .dmem_req_we_o(dwe64),
    .dmem_req_addr_o(daddr64), .dmem_req_be_o(dbe64), .dmem_req_wdata_o(dwdata64),
    .dmem_rsp_valid_i(rspv64), .dmem_rsp_rdata_i(rdata64),
    .ld_valid_o(ldv64), .ld_data_o(ldd64), .ld_rd_o(ldrd64),
    .misaligned_o(mis64), .busy_o(busy64)
  );

  // Scoreboard: every writeback pulse must match the oldest expected load.
  always @(negedge clk) begin
    if (rst_n && ld_valid) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_ld: ld_valid=1 data=%h rd=%0d, required no writeback", ld_data, ld_rd);
      end else begin
        e_mon = sb.pop_front();
        if (ld_data !== e_mon.data || ld_rd !== e_mon.rd) begin
          n_fail++;
          $display("FAIL ld_result: data=%h rd=%0d, required data=%h rd=%0d", ld_data, ld_rd, e_mon.data, e_mon.rd);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic set_req(input logic op, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd);
    req_valid = 1'b1; req_op = op; req_size = size; req_uns = uns;
    req_addr = addr; req_wdata = wdata; req_rd = rd;
  endtask

  // Offers one op and returns in the cycle after acceptance (or after the bound).
  task automatic issue(input logic op, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd,
                       output bit acc);
    set_req(op, size, uns, addr, wdata, rd);
    acc = 1'b0;
    for (int i = 0; i < 20 && !acc; i++) begin
      @(negedge clk);
      acc = req_ready;
      step();
    end
    req_valid = 1'b0;
  endtask

  task automatic respond(input logic [31:0] data);
    rsp_valid = 1'b1; rsp_rdata = data;
    step();
    rsp_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) step();
    n_cmp++; if ({dv, dwe, daddr, dbe, dwdata} !== '0) begin n_fail++; $display("FAIL rst_req: got v=%b we=%b a=%h be=%b wd=%h, required all 0", dv, dwe, daddr, dbe, dwdata); end
    n_cmp++; if ({ld_valid, ld_data, ld_rd, mis, busy} !== '0) begin n_fail++; $display("FAIL rst_ld: got lv=%b ld=%h rd=%0d mis=%b busy=%b, required all 0", ld_valid, ld_data, ld_rd, mis, busy); end
    rst_n = 1'b1;
    step();
    n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b, required 1", req_ready); end
  endtask

  task automatic test_byte_store();
    bit acc;
    mem_ready = 1'b1;
    issue(1'b1, 2'b10, 1'b0, 32'h1003, 32'h0000_00AB, 5'd0, acc);
    n_cmp++; if (acc !== 1'b1) begin n_fail++; $display("FAIL st_accept: got %b, required 1", acc); end
    n_cmp++; if (dv !== 1'b1 || dwe !== 1'b1) begin n_fail++; $display("FAIL st_valid: got v=%b we=%b, required 1 1", dv, dwe); end
    n_cmp++; if (daddr !== 32'h1000 || dbe !== 4'b1000) begin n_fail++; $display("FAIL st_addr_be: got %h %b, required 00001000 1000", daddr, dbe); end
    n_cmp++; if (dwdata !== 32'hABAB_ABAB) begin n_fail++; $display("FAIL st_wdata: got %h, required abababab", dwdata); end
    step();
    n_cmp++; if (dv !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL st_done: got v=%b busy=%b, required 0 0", dv, busy); end
  endtask

  task automatic half_load(input logic uns, input logic [4:0] rd, input logic [31:0] exp_data);
    bit acc;
    sb.push_back('{data: exp_data, rd: rd});
    issue(1'b0, 2'b01, uns, 32'h2002, 32'h0, rd, acc);
    n_cmp++; if (acc !== 1'b1 || dv !== 1'b1 || dwe !== 1'b0) begin n_fail++; $display("FAIL hl_issue: got acc=%b v=%b we=%b, required 1 1 0", acc, dv, dwe); end
    n_cmp++; if (daddr !== 32'h2000 || dbe !== 4'b1100) begin n_fail++; $display("FAIL hl_addr_be: got %h %b, required 00002000 1100", daddr, dbe); end
    step();
    respond(32'h8001_0000);
    n_cmp++; if (ld_valid !== 1'b1 || ld_rd !== rd) begin n_fail++; $display("FAIL hl_wb: got lv=%b rd=%0d, required 1 %0d", ld_valid, ld_rd, rd); end
    step();
    n_cmp++; if (ld_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL hl_pulse: got lv=%b busy=%b, required 0 0", ld_valid, busy); end
  endtask

  task automatic test_half_load();
    mem_ready = 1'b1;
    half_load(1'b0, 5'd5, 32'hFFFF_8001);
    half_load(1'b1, 5'd6, 32'h0000_8001);
  endtask

  task automatic test_back_to_back();
    mem_ready = 1'b1;
    sb.push_back('{data: 32'h1122_3344, rd: 5'd1});
    set_req(1'b0, 2'b00, 1'b0, 32'h100, 32'h0, 5'd1);
    @(negedge clk);
    n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_acc1: got %b, required 1", req_ready); end
    step();
    sb.push_back('{data: 32'hFFFF_FFF0, rd: 5'd2});
    set_req(1'b0, 2'b10, 1'b0, 32'h101, 32'h0, 5'd2);
    @(negedge clk);
    n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_acc2: got %b, required 1", req_ready); end
    step();
    sb.push_back('{data: 32'h0000_BEEF, rd: 5'd3});
    set_req(1'b0, 2'b01, 1'b1, 32'h102, 32'h0, 5'd3);
    @(negedge clk);
    n_cmp++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_full: got %b, required 0", req_ready); end
    step();
    rsp_valid = 1'b1; rsp_rdata = 32'h1122_3344;
    @(negedge clk);
    n_cmp++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_rsp_same_cycle: got %b, required 0", req_ready); end
    step();
    rsp_valid = 1'b0;
    n_cmp++; if (ld_valid !== 1'b1 || ld_rd !== 5'd1) begin n_fail++; $display("FAIL b2b_wb1: got lv=%b rd=%0d, required 1 1", ld_valid, ld_rd); end
    @(negedge clk);
    n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_acc3: got %b, required 1", req_ready); end
    step();
    req_valid = 1'b0;
    n_cmp++; if (dv !== 1'b1 || daddr !== 32'h100 || dbe !== 4'b1100) begin n_fail++; $display("FAIL b2b_issue3: got v=%b a=%h be=%b, required 1 00000100 1100", dv, daddr, dbe); end
    step();
    respond(32'h0000_F000);
    respond(32'hBEEF_0000);
    step();
  endtask

  task automatic test_backpressure();
    bit acc;
    mem_ready = 1'b0;
    issue(1'b1, 2'b00, 1'b0, 32'h500, 32'hCAFE_F00D, 5'd0, acc);
    set_req(1'b1, 2'b10, 1'b0, 32'h601, 32'h0000_005A, 5'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++; if (req_ready !== 1'b0 || dv !== 1'b1) begin n_fail++; $display("FAIL bp_hold%0d: got rdy=%b v=%b, required 0 1", i, req_ready, dv); end
      n_cmp++; if (daddr !== 32'h500 || dbe !== 4'hF || dwdata !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL bp_stable%0d: got %h %b %h, required 00000500 1111 cafef00d", i, daddr, dbe, dwdata); end
      step();
    end
    mem_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release: got %b, required 1", req_ready); end
    step();
    req_valid = 1'b0;
    n_cmp++; if (dv !== 1'b1 || daddr !== 32'h600 || dbe !== 4'b0010 || dwdata !== 32'h5A5A_5A5A) begin n_fail++; $display("FAIL bp_next: got v=%b %h %b %h, required 1 00000600 0010 5a5a5a5a", dv, daddr, dbe, dwdata); end
    step();
    n_cmp++; if (dv !== 1'b0) begin n_fail++; $display("FAIL bp_drain: got %b, required 0", dv); end
  endtask

  task automatic test_misaligned();
    bit acc;
    mem_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      if (k == 0) issue(1'b0, 2'b00, 1'b0, 32'h3002, 32'h0, 5'd4, acc);
      else        issue(1'b0, 2'b11, 1'b0, 32'h3000, 32'h0, 5'd4, acc);
      n_cmp++; if (acc !== 1'b1 || mis !== 1'b1) begin n_fail++; $display("FAIL mis_pulse%0d: got acc=%b mis=%b, required 1 1", k, acc, mis); end
      n_cmp++; if (dv !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL mis_noreq%0d: got v=%b busy=%b, required 0 0", k, dv, busy); end
      step();
      n_cmp++; if (mis !== 1'b0) begin n_fail++; $display("FAIL mis_once%0d: got %b, required 0", k, mis); end
    end
  endtask

  task automatic test_reset_flush();
    bit acc;
    mem_ready = 1'b1;
    issue(1'b0, 2'b00, 1'b0, 32'h700, 32'h0, 5'd7, acc);
    step();
    mem_ready = 1'b0;
    issue(1'b1, 2'b00, 1'b0, 32'h800, 32'h1234_5678, 5'd0, acc);
    n_cmp++; if (dv !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL rf_pre: got v=%b busy=%b, required 1 1", dv, busy); end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    n_cmp++; if ({dv, dwe, daddr, dbe, dwdata, ld_valid, ld_data, ld_rd, mis, busy} !== '0) begin n_fail++; $display("FAIL rf_zero: got v=%b a=%h be=%b busy=%b lv=%b, required all 0", dv, daddr, dbe, busy, ld_valid); end
    mem_ready = 1'b1;
    respond(32'hDEAD_BEEF);
    n_cmp++; if (ld_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rf_late_rsp: got lv=%b busy=%b, required 0 0", ld_valid, busy); end
  endtask

  task automatic test_random_loads();
    bit acc;
    logic [31:0] rd_data, lane, expv, addr;
    logic [1:0]  size;
    logic        uns;
    mem_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      rd_data = $urandom;
      uns     = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) begin
        size = 2'b10;
        addr = 32'h900 + 32'($urandom_range(0, 3));
        lane = (rd_data >> (8 * addr[1:0])) & 32'hFF;
        expv = uns ? lane : (lane ^ 32'h80) - 32'h80;
      end else begin
        size = 2'b01;
        addr = 32'h900 + 32'(2 * $urandom_range(0, 1));
        lane = (rd_data >> (8 * addr[1:0])) & 32'hFFFF;
        expv = uns ? lane : (lane ^ 32'h8000) - 32'h8000;
      end
      sb.push_back('{data: expv, rd: 5'(i + 10)});
      issue(1'b0, size, uns, addr, 32'h0, 5'(i + 10), acc);
      n_cmp++; if (acc !== 1'b1) begin n_fail++; $display("FAIL rnd_accept%0d: got %b, required 1", i, acc); end
      step();
      respond(rd_data);
    end
    step();
  endtask

  task automatic load64(input logic [1:0] size, input logic [31:0] addr, input logic [4:0] rd,
                        input logic [63:0] data, input logic [31:0] exp_addr,
                        input logic [7:0] exp_be, input logic [63:0] exp_data);
    v64 = 1'b1; op64 = 1'b0; size64 = size; uns64 = 1'b0; addr64 = addr; rd64 = rd;
    @(negedge clk);
    n_cmp++; if (rdy64 !== 1'b1) begin n_fail++; $display("FAIL x64_ready: got %b, required 1", rdy64); end
    step();
    v64 = 1'b0;
    n_cmp++; if (dv64 !== 1'b1 || mis64 !== 1'b0 || daddr64 !== exp_addr || dbe64 !== exp_be) begin n_fail++; $display("FAIL x64_req: got v=%b mis=%b a=%h be=%b, required 1 0 %h %b", dv64, mis64, daddr64, dbe64, exp_addr, exp_be); end
    step();
    rspv64 = 1'b1; rdata64 = data;
    step();
    rspv64 = 1'b0;
    n_cmp++; if (ldv64 !== 1'b1 || ldd64 !== exp_data || ldrd64 !== rd) begin n_fail++; $display("FAIL x64_wb: got lv=%b d=%h rd=%0d, required 1 %h %0d", ldv64, ldd64, ldrd64, exp_data, rd); end
    step();
  endtask

  task automatic test_xlen64();
    load64(2'b11, 32'h4008, 5'd9, 64'h0123_4567_89AB_CDEF, 32'h4008, 8'hFF, 64'h0123_4567_89AB_CDEF);
    load64(2'b00, 32'h4004, 5'd10, 64'h89AB_CDEF_0000_0000, 32'h4000, 8'hF0, 64'hFFFF_FFFF_89AB_CDEF);
  endtask

  initial begin
    req_valid = 1'b0; req_op = 1'b0; req_size = 2'b00; req_uns = 1'b0;
    req_addr = '0; req_wdata = '0; req_rd = '0;
    mem_ready = 1'b0; rsp_valid = 1'b0; rsp_rdata = '0;
    v64 = 1'b0; op64 = 1'b0; size64 = 2'b00; uns64 = 1'b0; addr64 = '0;
    wdata64 = '0; rd64 = '0; rspv64 = 1'b0; rdata64 = '0;
    step();
    test_reset();
    test_byte_store();
    test_half_load();
    test_back_to_back();
    test_backpressure();
    test_misaligned();
    test_reset_flush();
    test_random_loads();
    test_xlen64();
    repeat (2) step();
    n_cmp++; if (sb.size() != 0) begin n_fail++; $display("FAIL sb_drain: got %0d outstanding, required 0", sb.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
